// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider (DIV/DIVU)
// for the EX stage; result feeds the HI/LO write port.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] rem;
  logic        sgn;
  logic        neg1;
  logic        neg2;

  logic [32:0] pr;
  logic [32:0] diff;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // dvd holds the unconsumed dividend bits in its upper part and
  // collects quotient bits at the bottom as they are produced
  assign pr   = {rem, dvd[31]};
  assign diff = pr - {1'b0, dvs};

  assign abs1 = (signed_div_i && opdata1_i[31]) ?
                (~opdata1_i + 32'd1) : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[31]) ?
                (~opdata2_i + 32'd1) : opdata2_i;

  assign q_fix = (sgn && (neg1 ^ neg2)) ? (~dvd + 32'd1) : dvd;
  assign r_fix = (sgn && neg1) ? (~rem + 32'd1) : rem;

  // control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      dvd      <= 32'd0;
      dvs      <= 32'd0;
      rem      <= 32'd0;
      sgn      <= 1'b0;
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= 64'd0;
          if (start_i && !annul_i) begin
            sgn  <= signed_div_i;
            neg1 <= opdata1_i[31];
            neg2 <= opdata2_i[31];
            dvd  <= abs1;
            dvs  <= abs2;
            rem  <= 32'd0;
            cnt  <= 6'd0;
            if (opdata2_i == 32'd0) state <= BYZERO;
            else                    state <= ON;
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            state    <= END;
            result_o <= 64'd0;
            ready_o  <= 1'b1;
          end
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
            cnt   <= 6'd0;
          end else if (cnt == 6'd32) begin
            state    <= END;
            cnt      <= 6'd0;
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end else begin
            // a borrow out of the 33-bit subtract means "no subtract"
            if (!diff[32]) begin
              rem <= diff[31:0];
              dvd <= {dvd[30:0], 1'b1};
            end else begin
              rem <= pr[31:0];
              dvd <= {dvd[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit
// covering latency, signs, divide-by-zero, annul and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // drive one division with start held, wait for ready, compare
  // against the scoreboard, then release start and check the drop
  task automatic run(input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp,
                     input int lat, input string tag);
    int n;
    logic [63:0] e;
    @(negedge clk);
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    op1 = $urandom;
    op2 = $urandom;
    signed_div = ~s;
    n = 0;
    while (n < 40 && ready !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    e = sb.pop_front();
    chk(tag, result, e);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_hold_rdy"}, {63'd0, ready}, 64'd1);
    chk({tag, "_hold_res"}, result, e);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop_rdy"}, {63'd0, ready}, 64'd0);
    chk({tag, "_drop_res"}, result, 64'd0);
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1;
    signed_div = 1'b0;
    op1 = 32'd0;
    op2 = 32'd0;
    start = 1'b0;
    annul = 1'b0;
    #1;
    chk("reset_rdy", {63'd0, ready}, 64'd0);
    chk("reset_res", result, 64'd0);
    #12;
    rst = 1'b0;

    run(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, "divu_100_7");
    run(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, "div_m7_2");
    run(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, "div_7_m2");
    run(1'b0, 32'h1234, 32'd0, 64'd0, 1, "divu_byzero");
    run(1'b1, 32'hFFFFFFFB, 32'd0, 64'd0, 1, "div_byzero");
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33,
        "div_intmin");
    run(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 33, "divu_max_1");
    run(1'b0, 32'hFFFFFFFF, 32'h80000000, 64'h7FFFFFFF_00000001, 33,
        "divu_big_dvs");
    run(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 33,
        "div_m7_m2");

    // annul after ten iterations; ready must never rise
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b0) seen = 1'b1;
    end
    chk("annul_no_ready", {63'd0, seen}, 64'd0);
    run(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, "divu_9_3");

    // reset while the result is presented drops outputs at once
    @(negedge clk);
    signed_div = 1'b0;
    op1 = 32'd50;
    op2 = 32'd5;
    start = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 40 && ready !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("end_ready_pre_rst", {63'd0, ready}, 64'd1);
    chk("end_res_pre_rst", result, 64'h00000000_0000000A);
    #2;
    rst = 1'b1;
    #1;
    chk("end_rst_rdy", {63'd0, ready}, 64'd0);
    chk("end_rst_res", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // reset mid-iteration, then a fresh division
    @(negedge clk);
    op1 = 32'd100;
    op2 = 32'd7;
    start = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("on_rst_rdy", {63'd0, ready}, 64'd0);
    chk("on_rst_res", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 32'd15, 32'd4, 64'h00000003_00000003, 33, "divu_15_4");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
